// File: rtl/width_conv_pkg.sv
// Shared types and widths for the 16-to-8 width converter.
package width_conv_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                    input logic              upper);
        return upper ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/width_16to8.sv
// Splits a 16-bit word into two bytes; first byte registered 1 cycle after accept.
// Outputs hold under downstream stall; a new word is taken only when idle or as the last byte drains.
module width_16to8
    import width_conv_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [15:0] data_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [7:0]  data_out
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                accept, consume;

    // Refill on the last byte's consume keeps the stream at one word per two cycles.
    assign ready_in  = (state_q == ST_IDLE) || ((state_q == ST_SECOND) && ready_out);
    assign accept    = valid_in && ready_in;
    assign consume   = valid_q && ready_out;
    assign valid_out = valid_q;
    assign data_out  = data_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hold_d  = data_in;
                    data_d  = pick_byte(data_in, MSB_FIRST);
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (consume) begin
                    data_d  = pick_byte(hold_q, !MSB_FIRST);
                    state_d = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (consume) begin
                    if (accept) begin
                        hold_d  = data_in;
                        data_d  = pick_byte(data_in, MSB_FIRST);
                        state_d = ST_FIRST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_width_16to8.sv
// Self-checking bench: per-cycle vector table, reset corner sequence, random scoreboard run.
module tb_width_16to8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  vin = '0;
    logic [1:0]  rin;
    logic [1:0]  vout;
    logic [1:0]  rout = '0;
    logic [15:0] din [2];
    logic [7:0]  dout [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sel;
        logic        vin;
        logic [15:0] din;
        logic        rout;
        logic        erin;
        logic        evout;
        logic [7:0]  edout;
        logic        chk_d;
    } row_t;

    row_t rows[$];

    always #5 clk = ~clk;

    width_16to8 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst),
        .valid_in(vin[0]), .ready_in(rin[0]), .data_in(din[0]),
        .valid_out(vout[0]), .ready_out(rout[0]), .data_out(dout[0])
    );

    width_16to8 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .valid_in(vin[1]), .ready_in(rin[1]), .data_in(din[1]),
        .valid_out(vout[1]), .ready_out(rout[1]), .data_out(dout[1])
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int sel, input logic v, input logic [15:0] d, input logic ro,
                       input logic erin, input logic evout, input logic [7:0] edout,
                       input logic chk_d);
        row_t r;
        r = '{sel, v, d, ro, erin, evout, edout, chk_d};
        rows.push_back(r);
    endtask

    task automatic apply_rows();
        for (int i = 0; i < rows.size(); i++) begin
            vin  = '0;
            rout = '0;
            vin[rows[i].sel]  = rows[i].vin;
            din[rows[i].sel]  = rows[i].din;
            rout[rows[i].sel] = rows[i].rout;
            @(negedge clk);
            check($sformatf("row%0d ready_in", i),  16'(rin[rows[i].sel]),  16'(rows[i].erin));
            check($sformatf("row%0d valid_out", i), 16'(vout[rows[i].sel]), 16'(rows[i].evout));
            if (rows[i].chk_d)
                check($sformatf("row%0d data_out", i), 16'(dout[rows[i].sel]), 16'(rows[i].edout));
            @(posedge clk);
            #1;
        end
        rows.delete();
        vin  = '0;
        rout = '0;
    endtask

    task automatic run_random(input int sel, input int cycles);
        logic [7:0]  q[$];
        logic        pending = 1'b0;
        logic [15:0] word = '0;
        logic        prev_stall = 1'b0;
        logic [7:0]  prev_d = '0;
        logic [7:0]  exp_b;
        for (int c = 0; c < cycles + 20; c++) begin
            if (c < cycles) begin
                if (!pending && ($urandom_range(0, 1) == 1)) begin
                    word    = 16'($urandom_range(0, 65535));
                    pending = 1'b1;
                end
                vin[sel]  = pending;
                din[sel]  = word;
                rout[sel] = 1'($urandom_range(0, 1));
            end else begin
                vin[sel]  = 1'b0;
                rout[sel] = 1'b1;
            end
            @(negedge clk);
            if (prev_stall) begin
                check("stall valid_out", 16'(vout[sel]), 16'd1);
                check("stall data_out", 16'(dout[sel]), 16'(prev_d));
            end
            if (vin[sel] && rin[sel]) begin
                if (sel == 0) begin
                    q.push_back(word[15:8]);
                    q.push_back(word[7:0]);
                end else begin
                    q.push_back(word[7:0]);
                    q.push_back(word[15:8]);
                end
                pending = 1'b0;
            end
            if (vout[sel] && rout[sel]) begin
                if (q.size() == 0) begin
                    check("random extra byte", 16'(dout[sel]), 16'hxxxx);
                end else begin
                    exp_b = q.pop_front();
                    check($sformatf("random byte dut%0d", sel), 16'(dout[sel]), 16'(exp_b));
                end
            end
            prev_stall = vout[sel] && !rout[sel];
            prev_d     = dout[sel];
            @(posedge clk);
            #1;
        end
        check($sformatf("random drained dut%0d", sel), 16'(q.size()), 16'd0);
        vin  = '0;
        rout = '0;
    endtask

    initial begin
        din[0] = '0;
        din[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset valid_out dut%0d", s), 16'(vout[s]), 16'd0);
            check($sformatf("reset data_out dut%0d", s),  16'(dout[s]), 16'h0000);
            check($sformatf("reset ready_in dut%0d", s),  16'(rin[s]),  16'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // sel vin din rout | ready_in valid_out data_out chk
        add(0, 1, 16'hA55A, 1, 1, 0, 8'h00, 1);
        add(0, 0, 16'h0000, 1, 0, 1, 8'hA5, 1);
        add(0, 0, 16'h0000, 1, 1, 1, 8'h5A, 1);
        add(0, 0, 16'h0000, 1, 1, 0, 8'h00, 0);
        add(0, 1, 16'h1234, 1, 1, 0, 8'h00, 0);
        add(0, 1, 16'h5678, 1, 0, 1, 8'h12, 1);
        add(0, 1, 16'h5678, 1, 1, 1, 8'h34, 1);
        add(0, 0, 16'h0000, 1, 0, 1, 8'h56, 1);
        add(0, 0, 16'h0000, 1, 1, 1, 8'h78, 1);
        add(0, 1, 16'hBEEF, 1, 1, 0, 8'h00, 0);
        add(0, 0, 16'h0000, 0, 0, 1, 8'hBE, 1);
        add(0, 0, 16'h0000, 0, 0, 1, 8'hBE, 1);
        add(0, 0, 16'h0000, 0, 0, 1, 8'hBE, 1);
        add(0, 0, 16'h0000, 1, 0, 1, 8'hBE, 1);
        add(0, 0, 16'h0000, 1, 1, 1, 8'hEF, 1);
        add(0, 1, 16'h2233, 1, 1, 0, 8'h00, 0);
        add(0, 1, 16'h4455, 1, 0, 1, 8'h22, 1);
        add(0, 1, 16'h4455, 0, 0, 1, 8'h33, 1);
        add(0, 1, 16'h4455, 1, 1, 1, 8'h33, 1);
        add(0, 0, 16'h0000, 1, 0, 1, 8'h44, 1);
        add(0, 0, 16'h0000, 1, 1, 1, 8'h55, 1);
        add(0, 0, 16'h0000, 1, 1, 0, 8'h00, 0);
        add(1, 1, 16'hC0DE, 1, 1, 0, 8'h00, 1);
        add(1, 0, 16'h0000, 1, 0, 1, 8'hDE, 1);
        add(1, 0, 16'h0000, 1, 1, 1, 8'hC0, 1);
        add(1, 0, 16'h0000, 1, 1, 0, 8'h00, 0);
        add(0, 1, 16'h0F0F, 1, 1, 0, 8'h00, 0);
        add(0, 0, 16'h0000, 1, 0, 1, 8'h0F, 1);
        add(0, 0, 16'h0000, 0, 0, 1, 8'h0F, 1);
        apply_rows();

        // Reset lands while the second byte is still pending.
        rst = 1'b1;
        #1;
        check("midreset valid_out", 16'(vout[0]), 16'd0);
        check("midreset data_out",  16'(dout[0]), 16'h0000);
        check("midreset ready_in",  16'(rin[0]),  16'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        add(0, 1, 16'h1111, 1, 1, 0, 8'h00, 1);
        add(0, 0, 16'h0000, 1, 0, 1, 8'h11, 1);
        add(0, 0, 16'h0000, 1, 1, 1, 8'h11, 1);
        add(0, 0, 16'h0000, 1, 1, 0, 8'h00, 0);
        add(0, 0, 16'h0000, 1, 1, 0, 8'h00, 0);
        apply_rows();

        run_random(0, 400);
        run_random(1, 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/width_16to8.md
WIDTH_16TO8 -- requirements
Module: width_16to8

Interface
REQ-001 Parameter MSB_FIRST, default 1: when 1, byte [15:8] is emitted first; when 0, byte [7:0] is emitted first.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  1  upstream 16-bit word valid.
REQ-005 ready_in  output  1  block can accept a word this cycle.
REQ-006 data_in  input  16  upstream word.
REQ-007 valid_out  output  1  registered; data_out holds a valid byte.
REQ-008 ready_out  input  1  downstream accepts the current byte.
REQ-009 data_out  output  8  registered output byte.

Function
REQ-010 A word SHALL be accepted on a rising edge where valid_in && ready_in; a byte SHALL be consumed on a rising edge where valid_out && ready_out.
REQ-011 The FSM SHALL have exactly three states: IDLE (empty), FIRST (first byte presented), SECOND (second byte presented).
REQ-012 IDLE: ready_in=1 and valid_out=0; on accept, the word is latched into a 16-bit holding register and the next state is FIRST.
REQ-013 FIRST: valid_out=1 and data_out=first byte; ready_in=0; on consume, the next state is SECOND; otherwise the state holds.
REQ-014 SECOND: valid_out=1 and data_out=second byte; ready_in=ready_out.
REQ-015 SECOND, consume with a simultaneous accept: the new word is latched and the next state is FIRST, with no idle bubble.
REQ-016 SECOND, consume without accept: the next state is IDLE.
REQ-017 SECOND, no consume: the state holds and no word is accepted.
REQ-018 Latency: the first byte SHALL appear on valid_out/data_out the cycle after accept (1 cycle).
REQ-019 Sustained throughput SHALL be one word per 2 cycles when valid_in=1 and ready_out=1 continuously.
REQ-020 data_out and valid_out SHALL remain stable while valid_out && !ready_out.
REQ-021 ready_in SHALL depend combinationally only on state and ready_out, never on valid_in.
REQ-022 valid_in while ready_in=0 SHALL be ignored; upstream holds data_in until accepted.
REQ-023 Byte order is set by MSB_FIRST: first byte = word[15:8] when 1, word[7:0] when 0; the second byte is the other half.
REQ-024 Bytes SHALL never be duplicated, dropped or reordered between reset events.
REQ-025 No register width wraps; the holding register is exactly 16 bits.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, valid_out=0, data_out=8'h00, holding register=16'h0000.
REQ-027 Reset asserted mid-word (FIRST or SECOND) SHALL discard the partial word; the pending second byte is never emitted.
REQ-028 After rst deasserts, ready_in=1 in the first cycle.

Structure
REQ-029 The three-state enum typedef SHALL reside in the shared package width_conv_pkg, together with the BYTE_W=8 and WORD_W=16 constants.
REQ-030 The block SHALL be a single module with no sub-module.
REQ-031 The FSM, holding register and output registers SHALL be sequential; ready_in is the only combinational output.

Verification
REQ-032 MSB_FIRST=1, single word 16'hA55A, ready_out=1 -> data_out 8'hA5 at cycle +1, then 8'h5A at cycle +2; valid_out low at cycle +3.
REQ-033 Back-to-back words 16'h1234 and 16'h5678, valid_in=1, ready_out=1 -> byte stream 12,34,56,78 on consecutive cycles; ready_in=1 only in IDLE and SECOND cycles.
REQ-034 16'hBEEF with ready_out=0 for 3 cycles in FIRST -> data_out stays 8'hBE and valid_out stays 1; ready_in=0 throughout; then EF follows.
REQ-035 MSB_FIRST=0, word 16'hC0DE -> bytes 8'hDE then 8'hC0.
REQ-036 rst pulsed while in SECOND with 16'h0F0F loaded -> valid_out=0 and data_out=0 immediately; the second byte is never emitted; the next accepted word 16'h1111 outputs 11,11.
REQ-037 Random valid_in/ready_out at 50% each against a scoreboard -> output byte sequence equals the input words split per MSB_FIRST.
